lif_neuron_array: RTL and testbench

LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

---
 rtl/lif_neuron_array.sv | 126 ++++++++++++
 tb/tb_lif_neuron_array.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// lif_neuron_array: N parallel leaky integrate-and-fire neurons sharing one
// leak mode and one programmable firing threshold.
//   clk, rst    : single clock, synchronous active-high reset
//   en          : step strobe, every channel updates once per enabled cycle
//   current     : per-channel input current, channel i at [i*W +: W]
//   leak_sel    : 00 -> 7/8, 01 -> 3/4, 10 -> 1/2, 11 -> no leak
//   cfg_we/cfg_thresh : threshold write; the write lands at the edge, so a
//                 step taken in the same cycle still compares against the old value
//   spike       : registered one-cycle fire pulse per channel
//   state       : registered membrane potential per channel
//   spike_cnt   : saturating count of all spikes across channels

// One neuron channel: membrane register, refractory counter, spike flop.
// fire is combinational so the top can count spikes in the same cycle.
module lif_lane #(
  parameter int W       = 8,
  parameter int REFRACT = 2,
  parameter int RW      = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] cur,
  input  logic [1:0]   leak_sel,
  input  logic [W-1:0] threshold,
  output logic         fire,
  output logic [W-1:0] st,
  output logic         spk
);
  logic [RW-1:0] refr;
  logic [W-1:0]  lk;
  logic [W:0]    sum;

  assign fire = (refr == '0) && (st >= threshold);

  // Each shift truncates on its own; the three-term sum is at most 7/8 of
  // st, so it cannot overflow W bits.
  always_comb begin
    lk = st;
    case (leak_sel)
      2'b00:   lk = (st >> 1) + (st >> 2) + (st >> 3);
      2'b01:   lk = (st >> 1) + (st >> 2);
      2'b10:   lk = st >> 1;
      default: lk = st;
    endcase
  end

  assign sum = {1'b0, cur} + {1'b0, lk};

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= '0;
      refr <= '0;
      spk  <= 1'b0;
    end else begin
      spk <= en & fire;
      if (en) begin
        if (refr != '0) begin
          refr <= refr - RW'(1);
          st   <= '0;
        end else if (fire) begin
          st   <= '0;
          refr <= RW'(REFRACT);
        end else begin
          st   <= sum[W] ? '1 : sum[W-1:0];
        end
      end
    end
  end
endmodule

module lif_neuron_array #(
  parameter int W           = 8,
  parameter int N           = 4,
  parameter int REFRACT     = 2,
  parameter int THRESH_INIT = 230
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N*W-1:0] current,
  input  logic [1:0]     leak_sel,
  input  logic           cfg_we,
  input  logic [W-1:0]   cfg_thresh,
  output logic [N-1:0]   spike,
  output logic [N*W-1:0] state,
  output logic [15:0]    spike_cnt
);
  // Refractory counter needs at least one bit even when REFRACT is 0.
  localparam int RW = (REFRACT < 2) ? 1 : $clog2(REFRACT + 1);

  logic [W-1:0] threshold;
  logic [N-1:0] fire;
  logic [16:0]  cnt_sum;

  always_ff @(posedge clk) begin
    if (rst)         threshold <= W'(THRESH_INIT);
    else if (cfg_we) threshold <= cfg_thresh;
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    lif_lane #(.W(W), .REFRACT(REFRACT), .RW(RW)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cur       (current[i*W +: W]),
      .leak_sel  (leak_sel),
      .threshold (threshold),
      .fire      (fire[i]),
      .st        (state[i*W +: W]),
      .spk       (spike[i])
    );
  end

  // 17-bit accumulate so the carry out signals saturation.
  always_comb begin
    cnt_sum = {1'b0, spike_cnt};
    if (en)
      for (int i = 0; i < N; i++) cnt_sum = cnt_sum + {16'd0, fire[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) spike_cnt <= '0;
    else     spike_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array at W=8, N=4, REFRACT=2, THRESH_INIT=230.
// Inputs change 1ns after a rising edge; outputs are sampled at that same point,
// i.e. they reflect the edge just taken.
module tb_lif_neuron_array;
  localparam int W = 8, N = 4;

  logic           clk = 1'b0;
  logic           rst, en, cfg_we;
  logic [N*W-1:0] current;
  logic [1:0]     leak_sel;
  logic [W-1:0]   cfg_thresh;
  logic [N-1:0]   spike;
  logic [N*W-1:0] state;
  logic [15:0]    spike_cnt;

  int n_vec = 0;
  int n_bad = 0;

  lif_neuron_array #(.W(W), .N(N), .REFRACT(2), .THRESH_INIT(230)) dut (
    .clk(clk), .rst(rst), .en(en), .current(current), .leak_sel(leak_sel),
    .cfg_we(cfg_we), .cfg_thresh(cfg_thresh), .spike(spike), .state(state),
    .spike_cnt(spike_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; cfg_we = 1'b0; current = '0;
    step();
    rst = 1'b0;
  endtask

  // Hand-computed with leak 7/8 (truncating shifts), current 40, threshold 230:
  // 40, 40+35, 40+64, 40+91, 40+113, 40+133, 40+150, 40+165, 40+178, 40+190,
  // then fire (0, spike), two refractory zeros, then integrate again.
  logic [7:0] seq_a [14] = '{40, 75, 104, 131, 153, 173, 190, 205, 218, 230, 0, 0, 0, 40};

  initial begin
    rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_thresh = '0;
    current = '0; leak_sel = 2'b00;
    step(); step();
    chk("rst_state", state, 32'd0);
    chk("rst_spike", {28'd0, spike}, 32'd0);
    chk("rst_cnt", {16'd0, spike_cnt}, 32'd0);
    rst = 1'b0;

    // Integrate to threshold, fire, refractory, resume
    current = {8'd0, 8'd0, 8'd0, 8'd40}; en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      chk($sformatf("a_state%0d", i), {24'd0, state[7:0]}, {24'd0, seq_a[i]});
      chk($sformatf("a_spike%0d", i), {28'd0, spike}, (i == 10) ? 32'd1 : 32'd0);
    end
    chk("a_others", {8'd0, state[31:8]}, 32'd0);
    chk("a_cnt", {16'd0, spike_cnt}, 32'd1);

    // Run up to a second fire, then reset mid-spike/refractory with a
    // concurrent threshold write that reset must override
    for (int i = 1; i <= 10; i++) step();
    chk("b_spike", {28'd0, spike}, 32'd1);
    chk("b_cnt", {16'd0, spike_cnt}, 32'd2);
    rst = 1'b1; cfg_we = 1'b1; cfg_thresh = 8'd10;
    step();
    chk("b_rst_state", state, 32'd0);
    chk("b_rst_spike", {28'd0, spike}, 32'd0);
    chk("b_rst_cnt", {16'd0, spike_cnt}, 32'd0);
    rst = 1'b0; cfg_we = 1'b0;

    // en gating: 1,0,0,1 -> 40,40,40,75 (would fire if threshold were 10)
    en = 1'b1; step();
    chk("c_state0", {24'd0, state[7:0]}, 32'd40);
    en = 1'b0; step();
    chk("c_state1", {24'd0, state[7:0]}, 32'd40);
    chk("c_spike1", {28'd0, spike}, 32'd0);
    step();
    chk("c_state2", {24'd0, state[7:0]}, 32'd40);
    chk("c_spike2", {28'd0, spike}, 32'd0);
    en = 1'b1; step();
    chk("c_state3", {24'd0, state[7:0]}, 32'd75);
    chk("c_spike3", {28'd0, spike}, 32'd0);

    // All channels at full current: 255 everywhere, then all fire together
    do_reset();
    current = {4{8'd255}}; en = 1'b1;
    step();
    chk("d_state1", state, 32'hFFFF_FFFF);
    chk("d_spike1", {28'd0, spike}, 32'd0);
    step();
    chk("d_state2", state, 32'd0);
    chk("d_spike2", {28'd0, spike}, 32'hF);
    chk("d_cnt2", {16'd0, spike_cnt}, 32'd4);
    step();
    chk("d_spike3", {28'd0, spike}, 32'd0);
    chk("d_cnt3", {16'd0, spike_cnt}, 32'd4);

    // Lowered threshold: ch1 60 then fires
    do_reset();
    cfg_we = 1'b1; cfg_thresh = 8'd50; step();
    cfg_we = 1'b0;
    current = {8'd0, 8'd0, 8'd60, 8'd0}; en = 1'b1;
    step();
    chk("e_state1", {24'd0, state[15:8]}, 32'd60);
    step();
    chk("e_state2", {24'd0, state[15:8]}, 32'd0);
    chk("e_spike2", {28'd0, spike}, 32'h2);
    chk("e_cnt", {16'd0, spike_cnt}, 32'd1);

    // Threshold write in the same cycle as a step: old threshold decides
    do_reset();
    current = {8'd0, 8'd0, 8'd60, 8'd0}; en = 1'b1;
    step();
    chk("f_state1", {24'd0, state[15:8]}, 32'd60);
    cfg_we = 1'b1; cfg_thresh = 8'd50;
    step();
    chk("f_state2", {24'd0, state[15:8]}, 32'd112);
    chk("f_spike2", {28'd0, spike}, 32'd0);
    cfg_we = 1'b0;
    step();
    chk("f_state3", {24'd0, state[15:8]}, 32'd0);
    chk("f_spike3", {28'd0, spike}, 32'h2);

    // Threshold 0: every eligible channel fires even with zero state
    do_reset();
    cfg_we = 1'b1; cfg_thresh = 8'd0; step();
    cfg_we = 1'b0; en = 1'b1;
    step();
    chk("g_spike", {28'd0, spike}, 32'hF);
    chk("g_cnt", {16'd0, spike_cnt}, 32'd4);

    // No leak: ch2 holds 100; then saturation to 255 under threshold 250
    do_reset();
    leak_sel = 2'b11; en = 1'b1;
    current = {8'd0, 8'd100, 8'd0, 8'd0};
    step();
    chk("h_state0", {24'd0, state[23:16]}, 32'd100);
    current = '0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("h_state%0d", i), {24'd0, state[23:16]}, 32'd100);
      chk($sformatf("h_spike%0d", i), {28'd0, spike}, 32'd0);
    end
    en = 1'b0; cfg_we = 1'b1; cfg_thresh = 8'd250; step();
    cfg_we = 1'b0; en = 1'b1;
    current = {8'd0, 8'd200, 8'd0, 8'd0};
    step();
    chk("h_sat", {24'd0, state[23:16]}, 32'd255);
    chk("h_sat_spike", {28'd0, spike}, 32'd0);

    // Leak modes 1/2 and 3/4 on ch3
    do_reset();
    leak_sel = 2'b10; en = 1'b1;
    current = {8'd100, 8'd0, 8'd0, 8'd0};
    step();
    chk("i_state0", {24'd0, state[31:24]}, 32'd100);
    current = '0;
    step();
    chk("i_half", {24'd0, state[31:24]}, 32'd50);
    leak_sel = 2'b01;
    step();
    chk("i_3q", {24'd0, state[31:24]}, 32'd37);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
